// File: rtl/voice_freq_scheduler.sv
// voice_freq_scheduler
// Shares one note/octave-to-frequency lookup table between NUM_VOICES synth
// voices. Requests are granted round-robin. A valid request drives the table,
// waits LUT_LAT cycles and captures the result. An out-of-range request
// completes at once with err set. In both cases the winning voice receives a
// one-cycle ack.
//
// Ports:
//   clk        system clock
//   reset      asynchronous active-high reset
//   req        per-voice request, held until that voice's ack
//   note_in    voice i note at [4i+3:4i] (0=C .. 11=B)
//   octave_in  voice i octave at [4i+3:4i] (valid 0..8)
//   ack        one-hot, one-cycle completion pulse
//   err        high with ack when the request was out of range
//   freq_out   result in centi-Hz, held until the next completion
//   lut_note   registered note driven to the lookup table
//   lut_octave registered octave driven to the lookup table
//   lut_freq   lookup table result
//   busy       high while a transaction is in WAIT or RESP
module voice_freq_scheduler #(
  parameter int NUM_VOICES = 4,
  parameter int FREQ_W     = 20,
  parameter int LUT_LAT    = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_VOICES-1:0]   req,
  input  logic [4*NUM_VOICES-1:0] note_in,
  input  logic [4*NUM_VOICES-1:0] octave_in,
  output logic [NUM_VOICES-1:0]   ack,
  output logic                    err,
  output logic [FREQ_W-1:0]       freq_out,
  output logic [3:0]              lut_note,
  output logic [3:0]              lut_octave,
  input  logic [FREQ_W-1:0]       lut_freq,
  output logic                    busy
);

  localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int CNT_W = (LUT_LAT > 1) ? $clog2(LUT_LAT) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]        gidx_q, gidx_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [NUM_VOICES-1:0]   ack_q, ack_d;
  logic                    err_q, err_d;
  logic [FREQ_W-1:0]       freq_q, freq_d;
  logic [3:0]              lut_note_q, lut_note_d;
  logic [3:0]              lut_octave_q, lut_octave_d;
  logic                    busy_q, busy_d;

  logic                    found_s;
  logic [IDX_W-1:0]        grant_s;
  logic [IDX_W-1:0]        cand_s;
  logic [3:0]              sel_note_s;
  logic [3:0]              sel_octave_s;
  logic                    bad_s;
  logic [IDX_W-1:0]        rr_next_s;

  function automatic logic [NUM_VOICES-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_VOICES-1:0] v;
    v      = {NUM_VOICES{1'b0}};
    v[idx] = 1'b1;
    return v;
  endfunction

  // Round-robin search: first set req bit at or above rr_ptr, wrapping around.
  always_comb begin
    found_s = 1'b0;
    grant_s = {IDX_W{1'b0}};
    cand_s  = {IDX_W{1'b0}};
    for (int k = 0; k < NUM_VOICES; k++) begin
      cand_s = IDX_W'((int'(rr_ptr_q) + k) % NUM_VOICES);
      if (!found_s && req[cand_s]) begin
        found_s = 1'b1;
        grant_s = cand_s;
      end else begin
        found_s = found_s;
      end
    end
  end

  assign sel_note_s   = note_in[{grant_s, 2'b00} +: 4];
  assign sel_octave_s = octave_in[{grant_s, 2'b00} +: 4];
  assign bad_s        = (sel_note_s > 4'd11) || (sel_octave_s > 4'd8);
  assign rr_next_s    = (grant_s == IDX_W'(NUM_VOICES - 1)) ? {IDX_W{1'b0}}
                                                            : grant_s + IDX_W'(1);

  // Next-state and registered-output logic for the IDLE/WAIT/RESP sequence.
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    gidx_d       = gidx_q;
    cnt_d        = cnt_q;
    ack_d        = {NUM_VOICES{1'b0}};
    err_d        = err_q;
    freq_d       = freq_q;
    lut_note_d   = lut_note_q;
    lut_octave_d = lut_octave_q;
    case (state_q)
      S_IDLE: begin
        if (found_s) begin
          gidx_d   = grant_s;
          rr_ptr_d = rr_next_s;
          if (bad_s) begin
            // Out-of-range: skip the table, finish next cycle with err.
            err_d   = 1'b1;
            freq_d  = {FREQ_W{1'b0}};
            ack_d   = onehot(grant_s);
            state_d = S_RESP;
          end else begin
            lut_note_d   = sel_note_s;
            lut_octave_d = sel_octave_s;
            cnt_d        = CNT_W'(LUT_LAT - 1);
            state_d      = S_WAIT;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (cnt_q == {CNT_W{1'b0}}) begin
          freq_d  = lut_freq;
          err_d   = 1'b0;
          ack_d   = onehot(gidx_q);
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_RESP: begin
        // err is only meaningful alongside ack, so it drops with it.
        err_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      rr_ptr_q     <= {IDX_W{1'b0}};
      gidx_q       <= {IDX_W{1'b0}};
      cnt_q        <= {CNT_W{1'b0}};
      ack_q        <= {NUM_VOICES{1'b0}};
      err_q        <= 1'b0;
      freq_q       <= {FREQ_W{1'b0}};
      lut_note_q   <= 4'd0;
      lut_octave_q <= 4'd0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      gidx_q       <= gidx_d;
      cnt_q        <= cnt_d;
      ack_q        <= ack_d;
      err_q        <= err_d;
      freq_q       <= freq_d;
      lut_note_q   <= lut_note_d;
      lut_octave_q <= lut_octave_d;
      busy_q       <= busy_d;
    end
  end

  assign ack        = ack_q;
  assign err        = err_q;
  assign freq_out   = freq_q;
  assign lut_note   = lut_note_q;
  assign lut_octave = lut_octave_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_voice_freq_scheduler.sv
// Bench for voice_freq_scheduler: one instance at LUT_LAT=1 and one at
// LUT_LAT=3, each fed by a behavioural lookup table.
module tb_voice_freq_scheduler;

  localparam int NV = 4;
  localparam int FW = 20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic [NV-1:0]   req1, ack1, req3, ack3;
  logic [4*NV-1:0] note1, oct1, note3, oct3;
  logic            err1, busy1, err3, busy3;
  logic [FW-1:0]   freq1, lutf1, freq3, lutf3;
  logic [3:0]      ln1, lo1, ln3, lo3;

  // Frequencies in centi-Hz, 4 significant figures.
  function automatic logic [FW-1:0] lut_model(input logic [3:0] n, input logic [3:0] o);
    case ({n, o})
      8'h94:   return 20'd44000;
      8'h00:   return 20'd1635;
      8'hB8:   return 20'd790200;
      8'h04:   return 20'd26160;
      8'h05:   return 20'd52330;
      default: return {12'd0, n, o};
    endcase
  endfunction

  assign lutf1 = lut_model(ln1, lo1);

  logic [FW-1:0] p1_q, p2_q;
  always @(posedge clk) begin
    p1_q <= lut_model(ln3, lo3);
    p2_q <= p1_q;
  end
  assign lutf3 = p2_q;

  voice_freq_scheduler #(.NUM_VOICES(NV), .FREQ_W(FW), .LUT_LAT(1)) u1 (
    .clk(clk), .reset(reset), .req(req1), .note_in(note1), .octave_in(oct1),
    .ack(ack1), .err(err1), .freq_out(freq1), .lut_note(ln1), .lut_octave(lo1),
    .lut_freq(lutf1), .busy(busy1)
  );

  voice_freq_scheduler #(.NUM_VOICES(NV), .FREQ_W(FW), .LUT_LAT(3)) u3 (
    .clk(clk), .reset(reset), .req(req3), .note_in(note3), .octave_in(oct3),
    .ack(ack3), .err(err3), .freq_out(freq3), .lut_note(ln3), .lut_octave(lo3),
    .lut_freq(lutf3), .busy(busy3)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Waits (bounded) at negedges until u1 acks; lat counts negedges waited.
  task automatic wait_ack1(inout int lat);
    while (ack1 == 4'd0 && lat < 30) begin
      @(negedge clk);
      lat++;
    end
  endtask

  // Single request on u1; inputs are scrambled right after the grant edge.
  task automatic txn1(input int v, input logic [3:0] n, input logic [3:0] o,
                      input logic [FW-1:0] ef, input logic ee, input int elat);
    logic [3:0] ln0, lo0;
    int lat;
    ln0 = ln1;
    lo0 = lo1;
    note1[4*v +: 4] = n;
    oct1[4*v +: 4]  = o;
    req1[v]         = 1'b1;
    @(negedge clk);
    lat = 1;
    note1[4*v +: 4] = ~n;
    oct1[4*v +: 4]  = ~o;
    wait_ack1(lat);
    chk("txn_ack", 32'(ack1), 32'(4'b0001 << v));
    chk("txn_latency", 32'(lat), 32'(elat));
    chk("txn_freq", 32'(freq1), 32'(ef));
    chk("txn_err", 32'(err1), 32'(ee));
    chk("txn_busy", 32'(busy1), 32'd1);
    if (ee) begin
      chk("txn_lut_note_kept", 32'(ln1), 32'(ln0));
      chk("txn_lut_oct_kept", 32'(lo1), 32'(lo0));
    end else begin
      chk("txn_lut_note", 32'(ln1), 32'(n));
      chk("txn_lut_oct", 32'(lo1), 32'(o));
    end
    req1[v] = 1'b0;
    @(negedge clk);
    chk("txn_ack_one_cycle", 32'(ack1), 32'd0);
    chk("txn_freq_hold", 32'(freq1), 32'(ef));
    chk("txn_err_clear", 32'(err1), 32'd0);
    chk("txn_idle_busy", 32'(busy1), 32'd0);
  endtask

  typedef struct {
    int         v;
    logic [3:0] n;
    logic [3:0] o;
    logic [FW-1:0] f;
    logic       e;
    int         lat;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int lat;
    logic [FW-1:0] exp_f[4];

    tbl[0] = '{v: 0, n: 4'd9,  o: 4'd4,  f: 20'd44000,  e: 1'b0, lat: 2};
    tbl[1] = '{v: 1, n: 4'd12, o: 4'd0,  f: 20'd0,      e: 1'b1, lat: 1};
    tbl[2] = '{v: 1, n: 4'd0,  o: 4'd9,  f: 20'd0,      e: 1'b1, lat: 1};
    tbl[3] = '{v: 3, n: 4'd11, o: 4'd8,  f: 20'd790200, e: 1'b0, lat: 2};
    tbl[4] = '{v: 2, n: 4'd0,  o: 4'd0,  f: 20'd1635,   e: 1'b0, lat: 2};
    tbl[5] = '{v: 0, n: 4'd0,  o: 4'd4,  f: 20'd26160,  e: 1'b0, lat: 2};
    tbl[6] = '{v: 3, n: 4'd15, o: 4'd15, f: 20'd0,      e: 1'b1, lat: 1};
    tbl[7] = '{v: 2, n: 4'd0,  o: 4'd5,  f: 20'd52330,  e: 1'b0, lat: 2};

    req1 = 4'd0; note1 = 16'd0; oct1 = 16'd0;
    req3 = 4'd0; note3 = 16'd0; oct3 = 16'd0;
    do_reset();

    // Reset state.
    chk("rst_ack", 32'(ack1), 32'd0);
    chk("rst_err", 32'(err1), 32'd0);
    chk("rst_freq", 32'(freq1), 32'd0);
    chk("rst_lut_note", 32'(ln1), 32'd0);
    chk("rst_lut_oct", 32'(lo1), 32'd0);
    chk("rst_busy", 32'(busy1), 32'd0);

    // Single-voice vectors.
    for (int i = 0; i < 8; i++) begin
      txn1(tbl[i].v, tbl[i].n, tbl[i].o, tbl[i].f, tbl[i].e, tbl[i].lat);
    end

    // All four voices at once from rr_ptr=0: served 0,1,2,3.
    do_reset();
    note1 = {4'd0, 4'd11, 4'd0, 4'd9};
    oct1  = {4'd4, 4'd8,  4'd0, 4'd4};
    exp_f[0] = 20'd44000; exp_f[1] = 20'd1635; exp_f[2] = 20'd790200; exp_f[3] = 20'd26160;
    req1 = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      lat = 0;
      @(negedge clk);
      lat = 1;
      wait_ack1(lat);
      chk("all_ack", 32'(ack1), 32'(4'b0001 << k));
      chk("all_spacing", 32'(lat), (k == 0) ? 32'd2 : 32'd3);
      chk("all_freq", 32'(freq1), 32'(exp_f[k]));
      req1[k] = 1'b0;
    end
    @(negedge clk);

    // Voice 2 served last leaves rr_ptr=3; then 1 and 3 together -> 3 first.
    txn1(2, 4'd0, 4'd5, 20'd52330, 1'b0, 2);
    note1[4 +: 4]  = 4'd0; oct1[4 +: 4]  = 4'd4;
    note1[12 +: 4] = 4'd9; oct1[12 +: 4] = 4'd4;
    req1 = 4'b1010;
    @(negedge clk);
    lat = 1;
    wait_ack1(lat);
    chk("rr_first_ack", 32'(ack1), 32'b1000);
    chk("rr_first_freq", 32'(freq1), 32'd44000);
    req1[3] = 1'b0;
    @(negedge clk);
    lat = 1;
    wait_ack1(lat);
    chk("rr_second_ack", 32'(ack1), 32'b0010);
    chk("rr_second_lat", 32'(lat), 32'd3);
    chk("rr_second_freq", 32'(freq1), 32'd26160);
    req1[1] = 1'b0;
    @(negedge clk);

    // LUT_LAT=3 instance: four edges to ack, table inputs stable in WAIT.
    note3[8 +: 4] = 4'd0; oct3[8 +: 4] = 4'd5;
    req3[2] = 1'b1;
    @(negedge clk);
    lat = 1;
    note3[8 +: 4] = 4'd7; oct3[8 +: 4] = 4'd2;
    while (ack3 == 4'd0 && lat < 30) begin
      chk("lat3_lut_note_stable", 32'(ln3), 32'd0);
      chk("lat3_lut_oct_stable", 32'(lo3), 32'd5);
      @(negedge clk);
      lat++;
    end
    chk("lat3_ack", 32'(ack3), 32'b0100);
    chk("lat3_latency", 32'(lat), 32'd4);
    chk("lat3_freq", 32'(freq3), 32'd52330);
    chk("lat3_err", 32'(err3), 32'd0);
    req3[2] = 1'b0;
    @(negedge clk);

    // Reset mid-WAIT with voice 0 still requesting.
    note1[3:0] = 4'd9; oct1[3:0] = 4'd4;
    req1[0] = 1'b1;
    @(negedge clk);
    chk("midrst_in_wait", 32'(busy1), 32'd1);
    reset = 1'b1;
    #1;
    chk("midrst_ack", 32'(ack1), 32'd0);
    chk("midrst_freq", 32'(freq1), 32'd0);
    chk("midrst_lut_note", 32'(ln1), 32'd0);
    chk("midrst_lut_oct", 32'(lo1), 32'd0);
    chk("midrst_busy", 32'(busy1), 32'd0);
    chk("midrst_err", 32'(err1), 32'd0);
    @(negedge clk);
    chk("midrst_no_ack", 32'(ack1), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    lat = 1;
    wait_ack1(lat);
    chk("midrst_reserve_ack", 32'(ack1), 32'b0001);
    chk("midrst_reserve_lat", 32'(lat), 32'd2);
    chk("midrst_reserve_freq", 32'(freq1), 32'd44000);
    req1[0] = 1'b0;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/voice_freq_scheduler.md
Name: voice_freq_scheduler

Overview:
- Shares one note/octave-to-frequency lookup table between NUM_VOICES synth voices.
- Each voice raises a request carrying a note and octave. The scheduler arbitrates round-robin, drives the table inputs, waits the table latency, captures the frequency, and returns it to the winning voice with a one-cycle ack.
- Sits between the keyboard/voice-allocation logic and the frequency lookup, ahead of the tone generators.
- Frequencies are in centi-Hz (A4 = 44000).

Parameters:
- NUM_VOICES, 4, number of requesting voices (2..8).
- FREQ_W, 20, frequency width in centi-Hz; must hold 790200 (B8).
- LUT_LAT, 1, lookup latency in cycles from lut_note/lut_octave stable to lut_freq valid; must be at least 1.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- req  in  NUM_VOICES  per-voice request; held high until that voice's ack.
- note_in  in  4*NUM_VOICES  voice i note at [4i+3:4i]; 0=C..11=B.
- octave_in  in  4*NUM_VOICES  voice i octave at [4i+3:4i]; valid 0..8.
- ack  out  NUM_VOICES  one-hot, one-cycle completion pulse.
- err  out  1  high with ack when the request was out of range.
- freq_out  out  FREQ_W  result; valid while ack is high, held until next completion.
- lut_note  out  4  registered note driven to the lookup table.
- lut_octave  out  4  registered octave driven to the lookup table.
- lut_freq  in  FREQ_W  lookup table result.
- busy  out  1  high in WAIT and RESP.

Behaviour:
- Reset (asynchronous, immediate): state=IDLE; ack=0, err=0, freq_out=0, lut_note=0, lut_octave=0, busy=0; rr_ptr=0, cnt=0. Any in-flight transaction is dropped with no ack; a voice still holding req is re-served after reset release.
- IDLE state:
  - If req==0, stay in IDLE.
  - Otherwise grant the first set req bit scanning from rr_ptr upward, with wrap-around. Latch its index as gidx.
  - If note>11 or octave>8: set err=1 and freq_out=0, go to RESP. lut_note/lut_octave are unchanged.
  - Otherwise load lut_note/lut_octave from the granted voice, set cnt=LUT_LAT-1, go to WAIT.
  - In both cases set rr_ptr=(gidx+1) mod NUM_VOICES at the grant edge.
- WAIT state:
  - If cnt==0: freq_out<=lut_freq, err<=0, go to RESP.
  - Otherwise cnt<=cnt-1.
  - lut_note/lut_octave are held stable throughout.
- RESP state: ack[gidx]=1 for exactly this one cycle, then go to IDLE.
- ack and err are registered. No state other than RESP asserts ack.
- Latency, grant edge to ack high:
  - Valid request: LUT_LAT+1 edges, so ack is high in the cycle after the (LUT_LAT+1)th edge.
  - Invalid request: 1 edge.
- Throughput: one transaction per LUT_LAT+2 cycles for a valid request, one per 2 cycles for an invalid one.
- Requester handshake:
  - The requester deasserts req on the edge at which its ack is high.
  - req still high in the following IDLE cycle counts as a new request.
  - note_in/octave_in are sampled only at the grant edge; later changes do not affect the transaction in flight.
- Simultaneous requests: only one grant per IDLE cycle. Losers keep req high and are served in rotation; no voice waits more than NUM_VOICES-1 transactions.
- req dropped mid-transaction: the transaction still completes and ack still pulses.
- rr_ptr wraps from NUM_VOICES-1 to 0.
- freq_out is stored at FREQ_W bits with no truncation; the largest value is 790200.

Test Plan:
- Reset, then voice0 requests note=9, octave=4, with a behavioural lookup model at LUT_LAT=1 -> ack=0001 two cycles after the grant edge, freq_out=44000, err=0; freq_out holds 44000 afterwards.
- After reset, all four voices request simultaneously with A4, C0, B8, C4 -> acks in order 0,1,2,3, three cycles apart; freq_out 44000, 1635, 790200, 26160.
- Round-robin check: voice2 served last (rr_ptr=3), then voices 1 and 3 request together -> voice3 acked first, then voice1.
- Voice1 requests note=12, octave=0, then note=0, octave=9 -> each gets ack=0010 one edge after grant, err=1, freq_out=0, lut_note/lut_octave unchanged.
- LUT_LAT=3, voice2 requests note=0, octave=5 -> ack four edges after grant, freq_out=52330; lut_note/lut_octave constant throughout WAIT.
- Reset asserted mid-WAIT while voice0 holds req -> all outputs 0 immediately, no ack. After release, voice0 is granted again and acked with the correct frequency.
